// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default frame format.
// The receiver imports this package too, so both ends agree on the frame shape.
package uart_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_STOP_BITS  = 2;
    localparam int DEF_PARITY_BIT = 1;

    typedef enum logic [2:0] {
        ST_READY     = 3'd0,
        ST_START_BIT = 3'd1,
        ST_TX_DATA   = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP_BIT  = 3'd4,
        ST_TX_DONE   = 3'd5
    } tx_state_e;

endpackage

// File: rtl/uart_parity.sv
// Even-parity generator: XOR reduction over a data word.
// Shared by the transmitter and the receiver.
module uart_parity #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    assign parity = ^data;

endmodule

// File: rtl/tx_fsm.sv
// UART transmitter: one line bit per Clk, start / data MSB first / optional even parity /
// stop bits / one guaranteed idle cycle, with CTS flow control and break frames.
module tx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int STOP_BITS  = DEF_STOP_BITS,
    parameter int PARITY_BIT = DEF_PARITY_BIT
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Tx_Start,
    input  logic [DATA_BITS-1:0] Tx_Data_In,
    input  logic                 Tx_Break,
    input  logic                 CTS,
    output logic                 Tx_Out,
    output logic                 Tx_Ready,
    output logic                 Tx_Done,
    output tx_state_e            State_Dbg
);

    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]        stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 brk_q, brk_d;
    logic                 tx_out_q, tx_out_d;
    logic                 tx_done_q, tx_done_d;
    logic [CW-1:0]        bit_idx;
    logic                 parity;

    uart_parity #(.WIDTH(DATA_BITS)) u_parity (
        .data   (data_q),
        .parity (parity)
    );

    // Handshake: a request is taken on a rising edge where the FSM is in Ready and both
    // Tx_Start and CTS are high; Tx_Data_In and Tx_Break are latched on that same edge.
    // Tx_Start is never queued, and CTS is only consulted at acceptance.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        data_d     = data_q;
        brk_d      = brk_q;

        case (state_q)
            ST_READY: begin
                if (Tx_Start && CTS) begin
                    data_d  = Tx_Data_In;
                    brk_d   = Tx_Break;
                    state_d = ST_START_BIT;
                end
            end
            ST_START_BIT: begin
                bit_cnt_d = '0;
                state_d   = ST_TX_DATA;
            end
            ST_TX_DATA: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d  = '0;
                    stop_cnt_d = '0;
                    state_d    = (PARITY_BIT != 0) ? ST_PARITY : ST_STOP_BIT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                stop_cnt_d = '0;
                state_d    = ST_STOP_BIT;
            end
            ST_STOP_BIT: begin
                if (stop_cnt_q == STOP_LAST) begin
                    stop_cnt_d = '0;
                    state_d    = ST_TX_DONE;
                end else begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            ST_TX_DONE: state_d = ST_READY;
            default:    state_d = ST_READY;
        endcase

        // Line value is computed for the state being entered so Tx_Out comes straight off a flop.
        bit_idx  = BIT_LAST - bit_cnt_d;
        tx_out_d = 1'b1;
        case (state_d)
            ST_START_BIT: tx_out_d = 1'b0;
            ST_TX_DATA:   tx_out_d = data_d[bit_idx] & ~brk_d;
            ST_PARITY:    tx_out_d = parity & ~brk_q;
            ST_STOP_BIT:  tx_out_d = ~brk_q;
            default:      tx_out_d = 1'b1;
        endcase
        tx_done_d = (state_d == ST_TX_DONE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_READY;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            data_q     <= '0;
            brk_q      <= 1'b0;
            tx_out_q   <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            data_q     <= data_d;
            brk_q      <= brk_d;
            tx_out_q   <= tx_out_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign Tx_Out    = tx_out_q;
    assign Tx_Done   = tx_done_q;
    assign Tx_Ready  = (state_q == ST_READY);
    assign State_Dbg = state_q;

endmodule

// File: tb/tb_tx_fsm.sv
// Bench for tx_fsm: directed frames plus random traffic, checked every cycle against
// a queue-of-line-bits reference model and a small behavioural frame decoder.
module tb_tx_fsm;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int SB = 2;
    localparam int PB = 1;
    localparam int FRAME_BITS = 1 + DW + PB + SB + 1;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          Tx_Start = 1'b0;
    logic [DW-1:0] Tx_Data_In = '0;
    logic          Tx_Break = 1'b0;
    logic          CTS = 1'b0;
    logic          Tx_Out;
    logic          Tx_Ready;
    logic          Tx_Done;
    tx_state_e     State_Dbg;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // clock / reset
    always #5 Clk = ~Clk;

    tx_fsm #(.DATA_BITS(DW), .STOP_BITS(SB), .PARITY_BIT(PB)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Tx_Start   (Tx_Start),
        .Tx_Data_In (Tx_Data_In),
        .Tx_Break   (Tx_Break),
        .CTS        (CTS),
        .Tx_Out     (Tx_Out),
        .Tx_Ready   (Tx_Ready),
        .Tx_Done    (Tx_Done),
        .State_Dbg  (State_Dbg)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: a frame is a list of {line_bit, done_flag}, shifted out one per cycle.
    logic [1:0] exp_q[$];
    logic m_ready = 1'b1;
    logic m_out   = 1'b1;
    logic m_done  = 1'b0;

    task automatic model_pop();
        logic [1:0] e;
        e = exp_q.pop_front();
        m_out   = e[1];
        m_done  = e[0];
        m_ready = 1'b0;
    endtask

    task automatic model_edge(input logic rst, input logic start, input logic [DW-1:0] data,
                              input logic brk, input logic cts);
        if (rst) begin
            exp_q.delete();
            m_ready = 1'b1; m_out = 1'b1; m_done = 1'b0;
        end else if (m_ready && start && cts) begin
            exp_q.push_back(2'b00);
            for (int i = DW - 1; i >= 0; i--) exp_q.push_back({data[i] & ~brk, 1'b0});
            if (PB != 0) exp_q.push_back({(^data) & ~brk, 1'b0});
            for (int i = 0; i < SB; i++) exp_q.push_back({~brk, 1'b0});
            exp_q.push_back(2'b11);
            model_pop();
        end else if (exp_q.size() > 0) begin
            model_pop();
        end else begin
            m_ready = 1'b1; m_out = 1'b1; m_done = 1'b0;
        end
    endtask

    logic obs_out, obs_ready, obs_done, prev_ready;

    // driver: one clock cycle with the given inputs, then compare against the model
    task automatic cycle(input logic rst, input logic start, input logic [DW-1:0] data,
                         input logic brk, input logic cts);
        Rst = rst; Tx_Start = start; Tx_Data_In = data; Tx_Break = brk; CTS = cts;
        @(posedge Clk);
        model_edge(rst, start, data, brk, cts);
        @(negedge Clk);
        cyc++;
        prev_ready = obs_ready;
        obs_out   = Tx_Out;
        obs_ready = Tx_Ready;
        obs_done  = Tx_Done;
        check_eq("tx_out", obs_out, m_out);
        check_eq("tx_ready", obs_ready, m_ready);
        check_eq("tx_done", obs_done, m_done);
    endtask

    // Send one frame from Ready; returns the line bits seen on cycles E+1..E+13, first bit in MSB.
    task automatic send_frame(input logic [DW-1:0] data, input logic brk,
                              output logic [FRAME_BITS-1:0] v, output logic done_last);
        v = '0;
        cycle(1'b0, 1'b1, data, brk, 1'b1);
        v = {v[FRAME_BITS-2:0], obs_out};
        for (int i = 1; i < FRAME_BITS; i++) begin
            cycle(1'b0, 1'b0, DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
            v = {v[FRAME_BITS-2:0], obs_out};
        end
        done_last = obs_done;
    endtask

    logic [FRAME_BITS-1:0] v;
    logic                  done_last;
    logic [FRAME_BITS-1:0] a5_seq;
    int                    starts[$];

    initial begin
        obs_ready = 1'b0;
        a5_seq = 13'b0_10100101_0_11_1;

        // reset
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
        check_eq("reset_out", Tx_Out, 1);
        check_eq("reset_ready", Tx_Ready, 1);
        check_eq("reset_state", State_Dbg, ST_READY);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // 8'hA5 exact line sequence and done pulse
        send_frame(8'hA5, 1'b0, v, done_last);
        check_eq("a5_seq", v, a5_seq);
        check_eq("a5_done", done_last, 1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // 8'h01: parity bit 1, decodes cleanly
        send_frame(8'h01, 1'b0, v, done_last);
        check_eq("p01_parity", v[3], 1);
        check_eq("p01_data", v[11:4], 8'h01);
        check_eq("p01_rx_err", {^v[11:3], ~&v[2:1]}, 2'b00);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // break frame: low for 12 cycles, then idle high, framing error at a receiver
        send_frame(8'h5A, 1'b1, v, done_last);
        check_eq("brk_low", v[12:1], 12'h000);
        check_eq("brk_idle", v[0], 1);
        check_eq("brk_frame_err", ~&v[2:1], 1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // CTS low holds off a request; start bit follows the first edge with CTS high
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
            check_eq("cts_hold", obs_out, 1);
        end
        cycle(1'b0, 1'b1, 8'h77, 1'b0, 1'b1);
        check_eq("cts_start", obs_out, 0);
        for (int i = 0; i < FRAME_BITS; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // back-to-back with Tx_Start held: second start bit 14 cycles after the first
        starts.delete();
        for (int i = 0; i < 2 * FRAME_BITS + 3; i++) begin
            cycle(1'b0, 1'b1, (starts.size() == 0) ? 8'h3C : 8'hC3, 1'b0, 1'b1);
            if (prev_ready && !obs_out) starts.push_back(cyc);
        end
        check_eq("b2b_count", starts.size(), 3);
        if (starts.size() >= 2) check_eq("b2b_period", starts[1] - starts[0], FRAME_BITS + 1);
        for (int i = 0; i < FRAME_BITS; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // reset mid-frame at E+5, then a normal frame
        cycle(1'b0, 1'b1, 8'hF0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 8'h0F, 1'b0, 1'b1);
        check_eq("rst_mid_out", obs_out, 1);
        check_eq("rst_mid_ready", obs_ready, 1);
        for (int i = 0; i < FRAME_BITS; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
            check_eq("rst_no_done", obs_done, 0);
        end
        send_frame(8'h96, 1'b0, v, done_last);
        check_eq("post_rst_data", v[11:4], 8'h96);
        check_eq("post_rst_done", done_last, 1);

        // random traffic including CTS drops mid-frame, breaks and occasional reset
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 99) < 2),
                  1'($urandom_range(0, 99) < 40),
                  DW'($urandom_range(0, 255)),
                  1'($urandom_range(0, 99) < 10),
                  1'($urandom_range(0, 99) < 70));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tx_fsm.md
TX_FSM -- requirements
Module: tx_fsm

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: number of data bits per frame.
REQ-002 SHALL have parameter STOP_BITS, default 2: number of stop bits per frame.
REQ-003 SHALL have parameter PARITY_BIT, default 1: 1 = one even-parity bit after data; 0 = no parity bit.
REQ-004 SHALL have port Clk  input  1: clock, all logic on rising edge.
REQ-005 SHALL have port Rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port Tx_Start  input  1: request to send Tx_Data_In.
REQ-007 SHALL have port Tx_Data_In  input  DATA_BITS: frame payload.
REQ-008 SHALL have port Tx_Break  input  1: sampled with Tx_Start; 1 = send a break frame.
REQ-009 SHALL have port CTS  input  1: clear-to-send, driven by the far receiver's RTS.
REQ-010 SHALL have port Tx_Out  output  1: serial line, idle high, driven directly from a flop.
REQ-011 SHALL have port Tx_Ready  output  1: high only in state Ready.
REQ-012 SHALL have port Tx_Done  output  1: one-cycle pulse at frame end.

Function
REQ-013 SHALL implement states Ready, Start_Bit, Tx_Data, Parity, Stop_Bit, Tx_Done.
REQ-014 SHALL transmit one bit per Clk cycle, with no baud divider.
REQ-015 SHALL accept a request on an edge where State==Ready, Tx_Start==1 and CTS==1, and latch Tx_Data_In and Tx_Break on that edge.
REQ-016 SHALL ignore Tx_Start outside Ready, and SHALL ignore it in Ready while CTS==0, with no queuing.
REQ-017 SHALL ignore changes to Tx_Data_In and Tx_Break after acceptance until the next acceptance.
REQ-018 SHALL drive Tx_Out=0 for one cycle (Start_Bit) starting the cycle after acceptance.
REQ-019 SHALL then drive DATA_BITS data bits MSB first, one per cycle (Tx_Data), using a bit counter that runs 0..DATA_BITS-1.
REQ-020 SHALL, if PARITY_BIT==1, drive one Parity cycle carrying the XOR of all latched data bits; if PARITY_BIT==0, SHALL go from Tx_Data directly to Stop_Bit.
REQ-021 SHALL drive STOP_BITS cycles of Tx_Out=1 (Stop_Bit), counted by a stop counter.
REQ-022 SHALL drive one Tx_Done cycle with Tx_Out=1 and Tx_Done=1, then return to Ready; this guaranteed idle bit lets the receiver re-arm.
REQ-023 SHALL, for a break request, drive all data bits 0, parity 0 and all stop bits 0, keeping frame length and timing identical.
REQ-024 SHALL give default frame timing from acceptance edge E: start at E+1, data at E+2..E+9, parity at E+10, stops at E+11..E+12, Tx_Done at E+13, Ready at E+14.
REQ-025 SHALL accept back-to-back requests, with the earliest next acceptance at the edge ending the first Ready cycle, for a 14-cycle minimum period at defaults.
REQ-026 SHALL let a frame in progress complete when CTS falls mid-frame.
REQ-027 SHALL give total frame cycles = 2 + DATA_BITS + PARITY_BIT + STOP_BITS, including the idle cycle.
REQ-028 SHALL drive Tx_Out=1 in Ready.

Reset
REQ-029 SHALL, when Rst==1 at an edge, set State=Ready, Tx_Out=1, Tx_Ready=1, Tx_Done=0, both counters 0, and the data and break latches 0.
REQ-030 SHALL, on reset mid-frame, abort the frame with Tx_Out high from the next cycle and no Tx_Done pulse.
REQ-031 SHALL give Rst priority over a simultaneous Tx_Start.

Structure
REQ-032 SHALL place the state enum and the default DATA_BITS/STOP_BITS/PARITY_BIT constants in shared package uart_pkg, which the receiver also imports.
REQ-033 SHALL use one sub-module, uart_parity: a parameterised XOR reduction over DATA_BITS, reusable by the receiver.
REQ-034 SHALL use a single sequential state/datapath process plus a combinational next-state process.

Verification
REQ-035 SHALL cover: defaults, CTS=1, Tx_Start with 8'hA5 -> Tx_Out sequence 0,1,0,1,0,0,1,0,1,0,1,1,1 on cycles E+1..E+13, Tx_Done at E+13.
REQ-036 SHALL cover: 8'h01 -> parity bit 1 at E+10, and a loopback receiver (CTS tied to its RTS) outputs 8'h01 with Data_Rdy_Out=1 and Rx_Error=0.
REQ-037 SHALL cover: Tx_Break=1 with any data -> Tx_Out low E+1..E+12, high E+13, and the loopback receiver reports Rx_Error[0]=1 and Rx_Error[2]=1.
REQ-038 SHALL cover: CTS=0 with Tx_Start held 5 cycles -> Tx_Out stays 1; CTS raised -> start bit one cycle after the first edge with CTS=1.
REQ-039 SHALL cover: Tx_Start held continuously with 8'h3C then 8'hC3 -> two frames, starts at E+1 and E+15, no gap beyond the Tx_Done cycle plus one Ready cycle.
REQ-040 SHALL cover: Rst asserted at E+5 -> Tx_Out=1 from E+6, Tx_Ready=1, no Tx_Done; a new request is accepted normally afterwards.
